// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and data access.
// One access in flight at a time; data has priority but fetch is guaranteed a slot after a bounded data streak.
module mem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int TIMEOUT = 15,
  parameter int FETCH_STARVE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_size,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_ack,
  output logic [31:0]       dm_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_start,
  output logic [2:0]        mem_access,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              timeout_err
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(FETCH_STARVE + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t        state;
  logic          owner_dm;
  logic [WW-1:0] wait_cnt;
  logic [SW-1:0] starve_cnt;
  logic          grant_if, grant_dm, done, starved;
  logic [31:0]   cap;
  logic          unused_addr_hi;
  assign starved        = starve_cnt == SW'(FETCH_STARVE);
  assign grant_if       = if_req & (~dm_req | starved);
  assign grant_dm       = dm_req & ~grant_if;
  assign done           = mem_ready | (wait_cnt == WW'(TIMEOUT - 1));
  assign cap            = mem_ready ? mem_rdata : '0;
  assign stall_if       = reset & if_req & ~if_ack;
  assign stall_mem      = reset & dm_req & ~dm_ack;
  assign unused_addr_hi = ^{if_addr[31:ADDR_W], dm_addr[31:ADDR_W]};
  // The mem_* command registers double as the latched request for the whole access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner_dm    <= 1'b0;
      wait_cnt    <= '0;
      starve_cnt  <= '0;
      mem_start   <= 1'b0;
      mem_access  <= '0;
      mem_size    <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_ack      <= 1'b0;
      dm_ack      <= 1'b0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant_if | grant_dm) begin
          owner_dm   <= grant_dm;
          mem_start  <= 1'b1;
          mem_access <= (grant_dm & dm_we) ? 3'b010 : 3'b001;
          mem_size   <= grant_dm ? dm_size : 2'b10;
          mem_addr   <= grant_dm ? dm_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
          mem_wdata  <= grant_dm ? dm_wdata : '0;
          starve_cnt <= grant_if ? '0 : starve_cnt + SW'(if_req & ~starved);
          state      <= ISSUE;
        end
        ISSUE: begin
          mem_start <= 1'b0;
          wait_cnt  <= '0;
          state     <= WAIT;
        end
        WAIT: if (done) begin
          state       <= RESP;
          mem_access  <= '0;
          timeout_err <= timeout_err | ~mem_ready;
          dm_ack      <= owner_dm;
          if_ack      <= ~owner_dm;
          dm_rdata    <= owner_dm ? ((mem_access == 3'b010) ? '0 : cap) : dm_rdata;
          if_rdata    <= owner_dm ? if_rdata : cap;
        end else begin
          wait_cnt <= wait_cnt + WW'(1);
        end
        default: begin
          if_ack <= 1'b0;
          dm_ack <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus directed sequences against mem_port_arbiter, memory side modelled by the bench.
module tb_mem_port_arbiter;
  logic        clk = 0, reset = 0;
  logic        if_req = 0, dm_req = 0, dm_we = 0, mem_ready = 0;
  logic [1:0]  dm_size = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic        if_ack, dm_ack, stall_if, stall_mem, mem_start, timeout_err;
  logic [31:0] if_rdata, dm_rdata, mem_wdata;
  logic [2:0]  mem_access;
  logic [1:0]  mem_size;
  logic [9:0]  mem_addr;
  typedef struct {
    logic dm; logic [2:0] access; logic [1:0] size; logic [9:0] addr; logic [31:0] wdata; logic [31:0] rdata;
  } exp_t;
  typedef struct {
    logic dm; logic we; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rd; int k; exp_t e;
  } vec_t;
  exp_t exp_q[$];
  vec_t vecs[5];
  int   total = 0, passed = 0;
  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_start(mem_start), .mem_access(mem_access), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic drive(input vec_t v);
    if (v.dm) begin
      dm_req = 1; dm_we = v.we; dm_size = v.size; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1; if_addr = v.addr;
    end
    exp_q.push_back(v.e);
  endtask
  // Memory responder: waits for mem_start, raises mem_ready k cycles later (k=0: never), checks the ack.
  task automatic serve(input int k, input logic [31:0] rd, output int start_wait);
    exp_t e;
    int   n, c;
    logic stable, acked;
    n = 0; c = 0; stable = 1; acked = 0;
    while (!mem_start && n < 20) begin @(negedge clk); n++; end
    start_wait = n;
    if (!mem_start || exp_q.size() == 0) begin
      total++;
      $display("FAIL no_start: mem_start=%0b after %0d cycles, queued=%0d", mem_start, n, exp_q.size());
    end else begin
      e = exp_q[0];
      chk("cmd", {mem_access, mem_size, mem_addr, mem_wdata}, {e.access, e.size, e.addr, e.wdata});
      while (!acked && c < 40) begin
        @(negedge clk); c++;
        acked = if_ack | dm_ack;
        if (!acked) begin
          if (mem_start || {mem_access, mem_size, mem_addr, mem_wdata} != {e.access, e.size, e.addr, e.wdata}
              || !(e.dm ? stall_mem : stall_if)) stable = 0;
          mem_ready = (c == k);
          mem_rdata = (c == k) ? rd : 32'hDEADBEEF;
        end
      end
      mem_ready = 0;
      e = exp_q.pop_front();
      if (!acked) begin
        total++;
        $display("FAIL no_ack: no ack within %0d cycles of mem_start", c);
      end else begin
        chk("wait_stable", stable, 1);
        chk("owner", {dm_ack, if_ack}, {e.dm, !e.dm});
        chk("rdata", e.dm ? dm_rdata : if_rdata, e.rdata);
        chk("stall_at_ack", e.dm ? stall_mem : stall_if, 0);
        chk("ack_latency", c, (k == 0) ? 16 : k + 1);
      end
    end
  endtask
  initial begin
    int   sw, n;
    logic spurious;
    exp_t e;
    vecs[0] = '{0, 0, 2'b00, 32'h40, 32'h0, 32'h00500093, 1, '{0, 3'b001, 2'b10, 10'h040, 32'h0, 32'h00500093}};
    vecs[1] = '{1, 1, 2'b01, 32'h3FE, 32'hBEEF, 32'h12345678, 1, '{1, 3'b010, 2'b01, 10'h3FE, 32'hBEEF, 32'h0}};
    vecs[2] = '{1, 0, 2'b10, 32'h1234, 32'hAAAA, 32'hCAFEF00D, 6, '{1, 3'b001, 2'b10, 10'h234, 32'hAAAA, 32'hCAFEF00D}};
    vecs[3] = '{1, 0, 2'b00, 32'hFFFFF401, 32'h0, 32'hAB, 2, '{1, 3'b001, 2'b00, 10'h001, 32'h0, 32'hAB}};
    vecs[4] = '{0, 0, 2'b00, 32'h3FC, 32'h0, 32'h13, 3, '{0, 3'b001, 2'b10, 10'h3FC, 32'h0, 32'h13}};
    if_req = 1; dm_req = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd", {mem_start, mem_access, mem_size, mem_addr, mem_wdata}, 0);
    chk("reset_flags", {if_ack, dm_ack, stall_if, stall_mem, timeout_err}, 0);
    if_req = 0; dm_req = 0; reset = 1;
    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i]);
      serve(vecs[i].k, vecs[i].rd, sw);
      chk("start_latency", sw, 1);
      if_req = 0; dm_req = 0;
      @(negedge clk);
    end
    // Both requesters held: expect D D D D F, then D with fetch idle, then D D D D F again.
    if_req = 1; if_addr = 32'h100;
    dm_req = 1; dm_we = 0; dm_size = 2'b10; dm_addr = 32'h200; dm_wdata = 32'h5555;
    for (int i = 0; i < 11; i++) begin
      e.dm = !(i == 4 || i == 10); e.access = 3'b001; e.size = 2'b10;
      e.addr = e.dm ? 10'h200 : 10'h100; e.wdata = e.dm ? 32'h5555 : 32'h0; e.rdata = 32'h1000 + i;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 11; i++) begin
      serve(1, 32'h1000 + i, sw);
      if (i == 4) if_req = 0;
      if (i == 5) if_req = 1;
    end
    if_req = 0; dm_req = 0;
    @(negedge clk);
    chk("terr_before", timeout_err, 0);
    dm_req = 1; dm_we = 0; dm_size = 2'b10; dm_addr = 32'h80; dm_wdata = 0;
    exp_q.push_back('{1, 3'b001, 2'b10, 10'h080, 32'h0, 32'h0});
    serve(0, 32'h0, sw);
    chk("terr_set", timeout_err, 1);
    dm_req = 0;
    @(negedge clk);
    drive(vecs[0]);
    serve(vecs[0].k, vecs[0].rd, sw);
    if_req = 0;
    chk("terr_sticky", timeout_err, 1);
    @(negedge clk);
    // Asynchronous reset in the middle of WAIT with the data request held.
    dm_req = 1; dm_we = 0; dm_size = 2'b10; dm_addr = 32'h300; dm_wdata = 0;
    n = 0;
    while (!mem_start && n < 20) begin @(negedge clk); n++; end
    if (!mem_start) begin total++; $display("FAIL rst_start: mem_start never seen"); end
    repeat (3) @(negedge clk);
    #2 reset = 0; mem_ready = 1; mem_rdata = 32'h99;
    #1;
    chk("rst_async_cmd", {mem_start, mem_access, mem_size, mem_addr, mem_wdata}, 0);
    chk("rst_async_flags", {if_ack, dm_ack, stall_if, stall_mem, timeout_err}, 0);
    chk("rst_async_rdata", {if_rdata, dm_rdata}, 0);
    @(negedge clk);
    reset = 1; mem_ready = 0;
    exp_q.delete();
    exp_q.push_back('{1, 3'b001, 2'b10, 10'h300, 32'h0, 32'h77});
    serve(1, 32'h77, sw);
    chk("rst_reissue", sw, 1);
    dm_req = 0;
    @(negedge clk);
    mem_ready = 1; mem_rdata = 32'hBAD;
    spurious = 0;
    repeat (3) begin
      @(negedge clk);
      if (if_ack | dm_ack | mem_start) spurious = 1;
    end
    mem_ready = 0;
    chk("stale_ready", spurious, 0);
    chk("rdata_hold", dm_rdata, 32'h77);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
